multdiv_iter: RTL and testbench

Iterative signed 32-bit multiply/divide unit that services the processor's multdiv handshake. The execute stage pulses `ctrl_MULT` or `ctrl_DIV` with operands present. This block captures the operands, runs a fixed-latency shift/add (Booth radix-2) or non-restoring divide sequence, then raises `data_resultRDY` for one cycle with the result and exception flag. It sits beside the execute stage as the responder end of the `ctrl_MULT`/`ctrl_DIV` → `data_resultRDY` interface.

---
 rtl/multdiv_iter.sv | 156 +++++++++++++++
 tb/tb_multdiv_iter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (non-restoring) unit.
// Fixed 32-cycle latency from the start edge; a one-cycle data_resultRDY strobe marks completion.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MULT  | Booth step per edge
// DIV   | non-restoring quotient bit per edge
// DONE  | results valid, data_resultRDY high
module multdiv_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [64:0] r_prod;
    logic [31:0] r_mcand;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_neg;
    logic        r_div_exc;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_start;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_acc_ext;
    logic [32:0] w_m_ext;
    logic [32:0] w_sum;
    logic [64:0] w_prod_nxt;
    logic        w_mul_ovf;
    logic [32:0] w_rem_sh;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_cnt == 6'd31);
    assign w_abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign w_abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Accumulator is widened to 33 bits so -2^31 multiplicands cannot overflow before the shift.
    assign w_acc_ext = {r_prod[64], r_prod[64:33]};
    assign w_m_ext   = {r_mcand[31], r_mcand};

    always_comb begin
        w_sum = w_acc_ext;
        case (r_prod[1:0])
            2'b01:   w_sum = w_acc_ext + w_m_ext;
            2'b10:   w_sum = w_acc_ext - w_m_ext;
            default: w_sum = w_acc_ext;
        endcase
    end

    assign w_prod_nxt = {w_sum, r_prod[32:1]};
    assign w_mul_ovf  = ~((&w_prod_nxt[64:32]) | ~(|w_prod_nxt[64:32]));

    assign w_rem_sh  = {r_rem[31:0], r_quo[31]};
    assign w_rem_nxt = r_rem[32] ? (w_rem_sh + {1'b0, r_dvsr}) : (w_rem_sh - {1'b0, r_dvsr});
    assign w_quo_nxt = {r_quo[30:0], ~w_rem_nxt[32]};

    always_comb begin
        w_state_nxt = r_state;
        if (ctrl_MULT) begin
            w_state_nxt = S_MULT;
        end else if (ctrl_DIV) begin
            w_state_nxt = S_DIV;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_MULT:  w_state_nxt = w_last ? S_DONE : S_MULT;
                S_DIV:   w_state_nxt = w_last ? S_DONE : S_DIV;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 6'd0;
            r_prod    <= 65'd0;
            r_mcand   <= 32'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
            r_dvsr    <= 32'd0;
            r_neg     <= 1'b0;
            r_div_exc <= 1'b0;
            r_result  <= 32'd0;
            r_exc     <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= 6'd0;
            r_prod    <= {32'd0, data_operandB, 1'b0};
            r_mcand   <= data_operandA;
            r_rem     <= 33'd0;
            r_quo     <= w_abs_a;
            r_dvsr    <= w_abs_b;
            r_neg     <= data_operandA[31] ^ data_operandB[31];
            r_div_exc <= (data_operandB == 32'd0) ||
                         ((data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF));
        end else begin
            case (r_state)
                S_MULT: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_result <= w_prod_nxt[32:1];
                        r_exc    <= w_mul_ovf;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        // Divide-by-zero and the one unrepresentable quotient both report 0.
                        if (r_div_exc) begin
                            r_result <= 32'd0;
                            r_exc    <= 1'b1;
                        end else begin
                            r_result <= r_neg ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
                            r_exc    <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == S_DONE);

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: latency, strobe count, results and exception flags.
module tb_multdiv_iter;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks;
    int n_err;

    multdiv_iter dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode: 0 = multiply, 1 = divide, 2 = both ctrl lines high
    task automatic do_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e, input string tag);
        int first;
        int hits;
        logic [31:0] strobe_r;
        logic        strobe_e;
        first    = 0;
        hits     = 0;
        strobe_r = 32'hDEAD_BEEF;
        strobe_e = 1'bx;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = (mode != 1);
        ctrl_DIV      = (mode != 0);
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                hits++;
                if (first == 0) begin
                    first    = k;
                    strobe_r = data_result;
                    strobe_e = data_exception;
                end
            end
        end
        chk({tag, "_latency"}, 32'(first), 32'd32);
        chk({tag, "_strobes"}, 32'(hits), 32'd1);
        chk({tag, "_result"}, strobe_r, exp_r);
        chk({tag, "_exc"}, {31'd0, strobe_e}, {31'd0, exp_e});
        chk({tag, "_held"}, data_result, exp_r);
    endtask

    initial begin
        int first;
        int hits;
        n_checks      = 0;
        n_err         = 0;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_result", data_result, 32'd0);
        chk("rst_exc", {31'd0, data_exception}, 32'd0);
        chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_op(0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3");
        do_op(0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf_2p32");
        do_op(0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_x-1");
        do_op(0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_-1x-1");
        do_op(0, 32'h8000_0000,  32'h0000_0001, 32'h8000_0000, 1'b0, "mul_min_x1");
        do_op(1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, "div_-7/2");
        do_op(1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7/-2");
        do_op(1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "div_-7/-2");
        do_op(1, 32'd100,        32'd7,         32'd14,        1'b0, "div_100/7");
        do_op(1, 32'd5,          32'd0,         32'd0,         1'b1, "div_5/0");
        do_op(1, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1, "div_min/-1");
        do_op(1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, "div_min/1");
        do_op(2, 32'd3,          32'd4,         32'd12,        1'b0, "both_ctrl");

        // Restart: multiply abandoned by a divide started at E10
        first = 0;
        hits  = 0;
        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                hits++;
                if (first == 0) first = k;
            end
            if (k == 9) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd20;
                data_operandB = 32'd5;
            end else if (k == 10) begin
                ctrl_DIV = 1'b0;
            end
        end
        chk("restart_first", 32'(first), 32'd42);
        chk("restart_strobes", 32'(hits), 32'd1);
        chk("restart_result", data_result, 32'd4);
        chk("restart_exc", {31'd0, data_exception}, 32'd0);

        // Reset mid-operation
        @(negedge clock);
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_exc", {31'd0, data_exception}, 32'd0);
        chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        hits  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) hits++;
        end
        chk("midrst_no_strobe", 32'(hits), 32'd0);
        do_op(0, 32'd6, 32'd6, 32'd36, 1'b0, "post_rst_6x6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
